// File: rtl/efx_gray_pkg.sv
// Shared Gray-code helpers and FSM state type for the Gray pointer CDC path.
// Both the source-side counter and the destination-side receiver use this package.
package efx_gray_pkg;

    localparam int GRAY_MAX_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        RUN   = 2'd2
    } state_t;

    // Narrower pointers are zero-extended by the caller; leading zeros leave the XOR prefix unchanged.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [4:0] popcount(input logic [GRAY_MAX_W-1:0] v);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 0; i < GRAY_MAX_W; i++) begin
            c = c + 5'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/efx_gray_ptr_rx_evt_cnt.sv
// Saturating pending-event counter: step adds one, a valid/ready pop removes one.
// A step that arrives while the counter is full and nothing is popped is lost, and ovf_o records it.
module efx_evt_cnt #(
    parameter int PEND_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              step_i,
    input  logic              ready_i,
    input  logic              clr_i,
    output logic [PEND_W-1:0] pend_o,
    output logic              valid_o,
    output logic              ovf_o
);

    logic [PEND_W-1:0] r_pend;
    logic              r_ovf;
    logic              w_pop;
    logic              w_sat;
    logic              w_lost;

    assign valid_o = (r_pend != '0);
    assign w_pop   = valid_o & ready_i;
    assign w_sat   = &r_pend;
    assign w_lost  = step_i & ~w_pop & w_sat;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pend <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (step_i && !w_pop && !w_sat) begin
                r_pend <= r_pend + 1'b1;
            end else if (!step_i && w_pop) begin
                r_pend <= r_pend - 1'b1;
            end
            // A fresh overflow in the clearing cycle must stay visible.
            if (w_lost) begin
                r_ovf <= 1'b1;
            end else if (clr_i) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign pend_o = r_pend;
    assign ovf_o  = r_ovf;

endmodule

// File: rtl/efx_gray_ptr_rx.sv
// Destination-side receiver for a synchronized Gray pointer: qualifies each change as a
// single forward step, counts steps into a pending-event counter and flags illegal transitions.
module efx_gray_ptr_rx
    import efx_gray_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int PEND_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [WIDTH-1:0]  gray_i,
    input  logic              clr_err_i,
    input  logic              evt_ready_i,
    output logic [WIDTH-1:0]  bin_o,
    output logic              step_o,
    output logic              evt_valid_o,
    output logic [PEND_W-1:0] pend_o,
    output logic              jump_err_o,
    output logic              ovf_o
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_g_q;
    logic [WIDTH-1:0] r_g_prev;
    logic [WIDTH-1:0] r_bin;
    logic             r_step;
    logic             r_jump_err;

    logic [WIDTH-1:0] w_d;
    logic [WIDTH-1:0] w_bin_q;
    logic [WIDTH-1:0] w_bin_prev;
    logic [WIDTH-1:0] w_delta;
    logic [4:0]       w_pc;
    logic             w_legal;
    logic             w_load;
    logic             w_step_now;
    logic             w_err_now;

    assign w_d        = r_g_q ^ r_g_prev;
    assign w_bin_q    = WIDTH'(gray2bin(GRAY_MAX_W'(r_g_q)));
    assign w_bin_prev = WIDTH'(gray2bin(GRAY_MAX_W'(r_g_prev)));
    assign w_delta    = w_bin_q - w_bin_prev;
    assign w_pc       = popcount(GRAY_MAX_W'(w_d));
    // Modular delta makes the all-ones to zero wrap a legal forward step.
    assign w_legal    = (w_pc == 5'd1) && (w_delta == WIDTH'(1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (en_i) w_state_nxt = ALIGN;
            ALIGN:   w_state_nxt = en_i ? RUN : IDLE;
            RUN:     if (!en_i) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_load     = 1'b0;
        w_step_now = 1'b0;
        w_err_now  = 1'b0;
        case (r_state)
            ALIGN: w_load = 1'b1;
            RUN: begin
                w_load     = 1'b1;
                w_step_now = w_legal;
                w_err_now  = (|w_d) & ~w_legal;
            end
            default: ;
        endcase
    end

    // Every evaluation re-baselines, so one bad transition raises at most one error event.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_g_q      <= '0;
            r_g_prev   <= '0;
            r_bin      <= '0;
            r_step     <= 1'b0;
            r_jump_err <= 1'b0;
        end else begin
            r_g_q  <= gray_i;
            r_step <= w_step_now;
            if (w_load) begin
                r_g_prev <= r_g_q;
                r_bin    <= w_bin_q;
            end
            if (w_err_now) begin
                r_jump_err <= 1'b1;
            end else if (clr_err_i) begin
                r_jump_err <= 1'b0;
            end
        end
    end

    efx_evt_cnt #(
        .PEND_W (PEND_W)
    ) u_evt_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .step_i  (w_step_now),
        .ready_i (evt_ready_i),
        .clr_i   (clr_err_i),
        .pend_o  (pend_o),
        .valid_o (evt_valid_o),
        .ovf_o   (ovf_o)
    );

    assign bin_o      = r_bin;
    assign step_o     = r_step;
    assign jump_err_o = r_jump_err;

endmodule

// File: doc/efx_gray_ptr_rx.md
Name: efx_gray_ptr_rx

Overview:
- Destination-domain consumer of a Gray-coded pointer or counter after it has passed the multi-stage synchronizer.
- Registers the synchronized Gray value, converts it to binary and qualifies each change as a legal single-step increment.
- Accumulates legal steps into a pending-event counter, drained by a valid/ready handshake.
- Flags illegal multi-bit jumps, backward steps and counter overflow as sticky errors.
- Used for CDC of LPDDR4 controller event counts, e.g. refresh/command-issue tallies, between core and user clocks.

Parameters:
- WIDTH, 4, Gray pointer width; legal range 2..16.
- PEND_W, 8, pending-event counter width; saturates at 2^PEND_W-1.

Ports:
- clk_i  in  1  destination clock.
- rst_i  in  1  asynchronous reset, active-high.
- en_i  in  1  enable tracking; low = idle, no steps counted.
- gray_i  in  WIDTH  Gray pointer, already synchronized to clk_i.
- clr_err_i  in  1  clears jump_err_o and ovf_o.
- evt_ready_i  in  1  consumer pops one event.
- bin_o  out  WIDTH  registered binary form of the last tracked pointer.
- step_o  out  1  one-cycle pulse per legal increment.
- evt_valid_o  out  1  pend_o != 0.
- pend_o  out  PEND_W  pending event count.
- jump_err_o  out  1  sticky: illegal pointer transition seen.
- ovf_o  out  1  sticky: step lost at saturation.

Behaviour:
- Reset (async, any time): g_q, g_prev, bin_o, pend_o = 0; step_o, jump_err_o, ovf_o = 0; state = IDLE. Reset mid-stream discards all pending events.
- g_q <= gray_i every cycle, in all states.
- FSM states:
  - IDLE: no step evaluation. g_prev holds. Pops are still honoured. en_i=1 -> ALIGN.
  - ALIGN: one cycle. g_prev <= g_q, bin_o <= gray2bin(g_q), no step. Then -> RUN, or -> IDLE if en_i=0.
  - RUN: evaluate every cycle; en_i=0 -> IDLE with pend_o retained.
- RUN evaluation, with d = g_q ^ g_prev and delta = gray2bin(g_q) - gray2bin(g_prev) mod 2^WIDTH:
  - popcount(d)=0: no action.
  - popcount(d)=1 and delta=1: legal step; step_o=1 next cycle; pend increments.
  - Any other nonzero d (multi-bit change, or backward single-bit step with delta = 2^WIDTH-1): jump_err_o <= 1; no step.
  - In all RUN cases: g_prev <= g_q and bin_o <= gray2bin(g_q). A fault re-baselines, so at most one error event is flagged per bad transition.
- Wrap-around: the transition from 2^WIDTH-1 to 0 has delta=1 and is a legal step.
- Latency: gray_i captured into g_q at edge E0; step_o, bin_o and pend_o update at E1; evt_valid_o high from E1 if pend_o was 0.
- Handshake:
  - pop = evt_valid_o & evt_ready_i.
  - pend next = pend + step - pop.
  - Simultaneous step and pop: pend unchanged.
  - evt_ready_i with pend=0: ignored.
- Saturation: pend = max, step=1, pop=0 -> pend holds, ovf_o <= 1, step_o still pulses.
- Sticky clear: clr_err_i clears both jump_err_o and ovf_o. A new set in the same cycle wins over clear.
- All outputs are registered; no combinational path from inputs to outputs except evt_valid_o, which is derived from the registered pend_o only.

Decomposition:
- Package efx_gray_pkg:
  - state enum {IDLE, ALIGN, RUN};
  - function gray2bin (XOR prefix from MSB);
  - function popcount;
  - shared by the existing source-side Gray counter.
- Sub-module efx_evt_cnt: saturating up/down pending counter with step, pop and ovf ports, reusable by other CDC event paths.
- Top level holds the FSM and Gray qualification.

Test Plan:
- Reset, en_i=1, gray_i stepping 0,1,3,2 (Gray 0..3) one change per 2 cycles, evt_ready_i=0 -> three step_o pulses, pend_o=3, bin_o=3, no errors.
- WIDTH=4, count through 15->0 (Gray 1000->0000), evt_ready_i=1 -> step_o on wrap, no jump_err_o, pend_o returns to 0 one cycle after each step.
- Jump: gray_i 0000->0011 in RUN -> jump_err_o=1 at E1, pend unchanged; next legal step 0011->0010 counted; clr_err_i -> jump_err_o=0.
- Backward: gray_i 0011->0001 (bin 2->1) -> jump_err_o=1, no step_o.
- PEND_W=2: 4 steps with evt_ready_i=0 -> pend_o=3 and ovf_o=1 on 4th step; then a step and pop in the same cycle -> pend_o stays 3.
- en_i=0 while gray_i changes, then en_i=1 -> ALIGN re-baselines with no step and no error; async rst_i pulse mid-count -> all outputs 0 immediately.
